// File: rtl/vx_sb_arbiter.sv
// Purpose : scoreboard-gated round-robin arbiter; NUM_REQS warps share one registered issue slot.
// Latency : 1 cycle from accept (req_valid_i & req_ready_o) to out_valid_o.
// Backpressure: out_ready_i low with out_valid_o high holds the output and blocks all grants.
//
// Ports:
//   clk_i, reset_ni           single clock, synchronous active-low reset
//   req_*_i / req_ready_o     per-requester request, payload, wb flag, rd/rs1/rs2/rs3 indices; one-hot accept
//   wb_valid_i/wb_wid_i/wb_rd_i  writeback release of busy[wid][rd]
//   out_valid_o/out_data_o/out_wid_o/out_ready_i  registered issue output
//   perf_stalls_o             stall-cycle counter, present only with VX_SB_ARBITER_PERF_EN defined
module vx_sb_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int NR_BITS  = 6,
    localparam int WIDW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int NREGS   = 1 << NR_BITS
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [NUM_REQS-1:0]          req_valid_i,
    input  logic [NUM_REQS*DATAW-1:0]    req_data_i,
    input  logic [NUM_REQS-1:0]          req_wb_i,
    input  logic [NUM_REQS*NR_BITS-1:0]  req_rd_i,
    input  logic [NUM_REQS*NR_BITS-1:0]  req_rs1_i,
    input  logic [NUM_REQS*NR_BITS-1:0]  req_rs2_i,
    input  logic [NUM_REQS*NR_BITS-1:0]  req_rs3_i,
    output logic [NUM_REQS-1:0]          req_ready_o,
    input  logic                         wb_valid_i,
    input  logic [WIDW-1:0]              wb_wid_i,
    input  logic [NR_BITS-1:0]           wb_rd_i,
    output logic                         out_valid_o,
    output logic [DATAW-1:0]             out_data_o,
    output logic [WIDW-1:0]              out_wid_o,
    input  logic                         out_ready_i
`ifdef VX_SB_ARBITER_PERF_EN
    ,
    output logic [31:0]                  perf_stalls_o
`endif
);

    logic [NUM_REQS-1:0][NREGS-1:0] busy_q, busy_d;
    logic [WIDW-1:0]                rr_ptr_q, rr_ptr_d;
    logic                           out_valid_q, out_valid_d;
    logic [DATAW-1:0]               out_data_q, out_data_d;
    logic [WIDW-1:0]                out_wid_q, out_wid_d;

    logic [NUM_REQS-1:0] req_elig;
    logic                can_accept;
    logic                gnt_found;
    logic                gnt_vld;
    logic [WIDW-1:0]     gnt_idx;
    logic [NR_BITS-1:0]  gnt_rd;

    // Eligibility looks only at registered busy bits: a writeback this cycle does not bypass.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_elig[i] = req_valid_i[i]
                && !busy_q[i][req_rs1_i[i*NR_BITS +: NR_BITS]]
                && !busy_q[i][req_rs2_i[i*NR_BITS +: NR_BITS]]
                && !busy_q[i][req_rs3_i[i*NR_BITS +: NR_BITS]]
                && (!req_wb_i[i] || !busy_q[i][req_rd_i[i*NR_BITS +: NR_BITS]]);
        end
    end

    assign can_accept = !out_valid_q || out_ready_i;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            if (!gnt_found && req_elig[(int'(rr_ptr_q) + k) % NUM_REQS]) begin
                gnt_found = 1'b1;
                gnt_idx   = WIDW'((int'(rr_ptr_q) + k) % NUM_REQS);
            end
        end
    end

    // Gating with reset keeps req_ready_o low while the state is being cleared.
    assign gnt_vld = reset_ni && can_accept && gnt_found;
    assign gnt_rd  = req_rd_i[int'(gnt_idx)*NR_BITS +: NR_BITS];

    always_comb begin
        req_ready_o = '0;
        if (gnt_vld) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Clear is applied before set so a same-cycle set of the same bit wins.
    // Register 0 is never marked, so it never reads busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i && (int'(wb_wid_i) < NUM_REQS)) begin
            busy_d[wb_wid_i][wb_rd_i] = 1'b0;
        end
        if (gnt_vld && req_wb_i[gnt_idx] && (gnt_rd != '0)) begin
            busy_d[gnt_idx][gnt_rd] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_wid_d   = out_wid_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_accept) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = req_data_i[int'(gnt_idx)*DATAW +: DATAW];
                out_wid_d  = gnt_idx;
                rr_ptr_d   = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            busy_q      <= '0;
            rr_ptr_q    <= WIDW'(NUM_REQS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_wid_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_wid_q   <= out_wid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_wid_o   = out_wid_q;

`ifdef VX_SB_ARBITER_PERF_EN
    logic [31:0] perf_stalls_q;

    // Counts cycles where someone is asking but nobody is granted; wraps naturally.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            perf_stalls_q <= '0;
        end else if ((|req_valid_i) && !gnt_vld) begin
            perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_stalls_o = perf_stalls_q;
`endif

endmodule
